uart_echo_responder: RTL and testbench
======================================

Name: uart_echo_responder

Overview:
- Remote-end partner of the UART loopback initiator on the second FPGA.
- Deserialises incoming 8N1 frames on rxd and buffers accepted bytes in a small FIFO.
- Retransmits each buffered byte on txd, XOR-ed with a mask, so the initiator sees its byte echoed back.
- Shows the last received byte on LEDs and keeps sticky error flags plus a frame counter for board debug.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be at least 4.
- FIFO_DEPTH, 8, echo buffer depth in bytes; power of two, at least 2.
- XOR_MASK, 8'h00, applied to each byte on transmit; 8'h00 gives a pure echo.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset; block is in reset while rst=0.
- rxd  input  1  serial input, idle high, asynchronous to clk.
- tx_hold  input  1  when 1, the TX engine does not start a new frame; a frame already in progress completes.
- txd  output  1  serial output, idle high.
- leds  output  8  last correctly framed received byte, not masked.
- rx_count  output  8  number of accepted frames, wraps 255 -> 0.
- overflow  output  1  sticky: a valid byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: a stop bit was sampled low.

Behaviour:
- Reset (rst=0, takes effect immediately):
  - txd=1, leds=0, rx_count=0, overflow=0, frame_err=0.
  - FIFO empty; both FSMs in IDLE.
  - A frame in progress is abandoned and txd goes high without waiting for a clock edge.
- RX input conditioning: rxd passes through a 2-flop synchroniser; all RX decisions use the synchronised value.
- RX FSM (IDLE, START, DATA, STOP, WAIT_IDLE):
  - IDLE: on a synchronised low, go to START and clear the bit timer.
  - START: at CLKS_PER_BIT/2 (integer divide), sample the line.
    - Low: go to DATA.
    - High: glitch; return to IDLE with no flag set.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first; then go to STOP.
  - STOP: sample one CLKS_PER_BIT later.
    - Stop bit high: byte is valid. Push it to the FIFO, load leds, increment rx_count, return to IDLE. These updates are visible the cycle after the sample.
    - Stop bit low: set frame_err, discard the byte, leds and rx_count unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronised line is high, then go to IDLE.
- FIFO: synchronous, pointers of log2(FIFO_DEPTH)+1 bits so full and empty are distinguishable.
  - Push while full with no pop in the same cycle: byte dropped, overflow set. leds and rx_count still update, because the frame itself was valid.
  - Push and pop in the same cycle while full: push accepted, no overflow.
  - Push and pop in the same cycle while empty: cannot occur, since pop requires not-empty in the prior cycle.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if FIFO not empty and tx_hold=0, pop and latch (byte ^ XOR_MASK); go to START on the next cycle.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
  - Frame length: exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames: idle gap of exactly 1 cycle between STOP end and the next START.
- Latency:
  - Push into an empty FIFO at cycle N: not-empty seen at N+1, pop at N+1, txd falls at N+2.
  - End-to-end: txd falls 2 cycles after the RX stop-bit sample cycle + 1.
- Counters: bit timers are just wide enough for CLKS_PER_BIT-1; bit index is 3 bits; rx_count wraps modulo 256.
- Sticky flags clear only on reset.

Test Plan (CLKS_PER_BIT=8, FIFO_DEPTH=4 unless stated):
- Single frame 0xA5 on rxd -> leds=0xA5 and rx_count=1 one cycle after the stop sample. txd carries frame 0,1,0,1,0,0,1,0,1,1 at 8 cycles per bit, starting 2 cycles after the push. overflow=0, frame_err=0.
- XOR_MASK=8'hFF, rx 0x3C -> leds=0x3C, txd data bits carry 0xC3.
- 3-cycle low glitch on idle rxd -> no push, rx_count=0, frame_err=0, txd stays 1.
- Frame 0x55 with stop bit forced low, then valid 0x11 -> frame_err=1, 0x55 never echoed, leds=0x11, rx_count=1.
- tx_hold=1, six back-to-back valid frames 0x01..0x06 -> FIFO holds 0x01..0x04, overflow=1, rx_count=6, leds=0x06. Release tx_hold -> exactly 0x01..0x04 echoed, with 1-cycle gaps between frames.
- Assert rst=0 mid-TX-frame at data bit 3 -> txd=1 immediately and all outputs at reset values. After release, a new 0x7E frame echoes correctly.

Source files
------------

// File: rtl/uart_echo_responder.sv
// uart_echo_responder
//   Remote-end UART echo partner. Receives 8N1 frames on rxd, buffers each
//   correctly framed byte in a small FIFO and retransmits it on txd XOR-ed
//   with XOR_MASK. Shows the last good byte on leds and keeps sticky
//   overflow / frame_err flags plus a wrapping frame counter for board debug.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   rxd        serial input, idle high, asynchronous to clk
//   tx_hold    1 = do not start a new TX frame (a running frame completes)
//   txd        serial output, idle high
//   leds       last correctly framed received byte (unmasked)
//   rx_count   number of accepted frames, wraps 255 -> 0
//   overflow   sticky: a valid byte was dropped because the FIFO was full
//   frame_err  sticky: a stop bit was sampled low
module uart_echo_responder #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  XOR_MASK     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       tx_hold,
  output logic       txd,
  output logic [7:0] leds,
  output logic [7:0] rx_count,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] BIT_HALF = TW'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // ---------------- RX ----------------
  logic            r_rx_meta, r_rx_sync;
  rx_state_e       r_rx_state, w_rx_next;
  logic [TW-1:0]   r_rx_timer;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            w_rx_timer_clr, w_rx_shift, w_rx_done, w_rx_ferr;
  logic            w_rxd;

  // ---------------- FIFO / TX ----------------
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]     r_wr_ptr, r_rd_ptr;
  logic            w_full, w_empty, w_push, w_pop;
  logic [7:0]      w_fifo_rdata;
  tx_state_e       r_tx_state, w_tx_next;
  logic [TW-1:0]   r_tx_timer;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_txd;
  logic            w_tx_timer_clr, w_tx_shift, w_tx_stop, w_tx_bit_inc;
  logic [7:0]      r_leds, r_rx_count;
  logic            r_overflow, r_frame_err;

  // Two-flop synchroniser; resets to the idle (high) line level.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rx_sync <= r_rx_meta;
    end
  end
  assign w_rxd = r_rx_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rx_state <= RX_IDLE;
    else      r_rx_state <= w_rx_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_rx_next      = r_rx_state;
    w_rx_timer_clr = 1'b0;
    w_rx_shift     = 1'b0;
    w_rx_done      = 1'b0;
    w_rx_ferr      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_timer_clr = 1'b1;
        if (!w_rxd) w_rx_next = RX_START;
      end
      RX_START: if (r_rx_timer == BIT_HALF) begin
        w_rx_timer_clr = 1'b1;
        // High at mid start bit is a glitch: drop it silently.
        w_rx_next = w_rxd ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (r_rx_timer == BIT_LAST) begin
        w_rx_timer_clr = 1'b1;
        w_rx_shift     = 1'b1;
        if (r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      end
      RX_STOP: if (r_rx_timer == BIT_LAST) begin
        w_rx_timer_clr = 1'b1;
        if (w_rxd) begin
          w_rx_done = 1'b1;
          w_rx_next = RX_IDLE;
        end else begin
          w_rx_ferr = 1'b1;
          w_rx_next = RX_WAIT_IDLE;
        end
      end
      RX_WAIT_IDLE: if (w_rxd) w_rx_next = RX_IDLE;
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_timer <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_timer <= w_rx_timer_clr ? '0 : r_rx_timer + 1'b1;
      if (r_rx_state == RX_IDLE) r_rx_bit <= '0;
      else if (w_rx_shift)       r_rx_bit <= r_rx_bit + 1'b1;
      if (w_rx_shift) r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
    end
  end

  // ---------------- FIFO ----------------
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_push       = w_rx_done && (!w_full || w_pop);
  assign w_fifo_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_leds      <= '0;
      r_rx_count  <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // The frame was valid even when it is dropped, so leds/count still update.
      if (w_rx_done) begin
        r_leds     <= r_rx_shift;
        r_rx_count <= r_rx_count + 1'b1;
      end
      if (w_rx_done && !w_push) r_overflow <= 1'b1;
      if (w_rx_ferr) r_frame_err <= 1'b1;
    end
  end

  // ---------------- TX ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tx_state <= TX_IDLE;
    else      r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next      = r_tx_state;
    w_tx_timer_clr = 1'b0;
    w_pop          = 1'b0;
    w_tx_shift     = 1'b0;
    w_tx_stop      = 1'b0;
    w_tx_bit_inc   = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_timer_clr = 1'b1;
        if (!w_empty && !tx_hold) begin
          w_pop     = 1'b1;
          w_tx_next = TX_START;
        end
      end
      TX_START: if (r_tx_timer == BIT_LAST) begin
        w_tx_timer_clr = 1'b1;
        w_tx_shift     = 1'b1;
        w_tx_next      = TX_DATA;
      end
      TX_DATA: if (r_tx_timer == BIT_LAST) begin
        w_tx_timer_clr = 1'b1;
        w_tx_bit_inc   = 1'b1;
        if (r_tx_bit == 3'd7) begin
          w_tx_stop = 1'b1;
          w_tx_next = TX_STOP;
        end else begin
          w_tx_shift = 1'b1;
        end
      end
      TX_STOP: if (r_tx_timer == BIT_LAST) begin
        w_tx_timer_clr = 1'b1;
        w_tx_next      = TX_IDLE;
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // txd is registered and driven one edge ahead of each bit period, so the
  // line changes on the same edge the FSM enters the matching state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txd      <= 1'b1;
      r_tx_shift <= '0;
      r_tx_timer <= '0;
      r_tx_bit   <= '0;
    end else begin
      r_tx_timer <= w_tx_timer_clr ? '0 : r_tx_timer + 1'b1;
      if (w_pop)             r_tx_bit <= '0;
      else if (w_tx_bit_inc) r_tx_bit <= r_tx_bit + 1'b1;
      if (w_pop) begin
        r_tx_shift <= w_fifo_rdata ^ XOR_MASK;
        r_txd      <= 1'b0;
      end else if (w_tx_shift) begin
        r_txd      <= r_tx_shift[0];
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
      end else if (w_tx_stop) begin
        r_txd      <= 1'b1;
      end
    end
  end

  assign txd       = r_txd;
  assign leds      = r_leds;
  assign rx_count  = r_rx_count;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Testbench for uart_echo_responder (CLKS_PER_BIT=8, FIFO_DEPTH=4).
// u_dut uses XOR_MASK=8'h00, u_dut_x uses XOR_MASK=8'hFF. Background
// monitors decode every frame seen on each txd into a queue.
module tb_uart_echo_responder;

  localparam int C = 8;

  logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1, rxd_x = 1'b1, tx_hold = 1'b0;
  logic       txd, txd_x, overflow, overflow_x, frame_err, frame_err_x;
  logic [7:0] leds, leds_x, rx_count, rx_count_x;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  uart_echo_responder #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .XOR_MASK(8'h00)) u_dut (
    .clk(clk), .rst(rst), .rxd(rxd), .tx_hold(tx_hold), .txd(txd), .leds(leds),
    .rx_count(rx_count), .overflow(overflow), .frame_err(frame_err));

  uart_echo_responder #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .XOR_MASK(8'hFF)) u_dut_x (
    .clk(clk), .rst(rst), .rxd(rxd_x), .tx_hold(tx_hold), .txd(txd_x), .leds(leds_x),
    .rx_count(rx_count_x), .overflow(overflow_x), .frame_err(frame_err_x));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle stamp of the most recent rx_count change on u_dut.
  int         last_cnt_cyc = 0;
  logic [7:0] prev_cnt = 8'h00;
  always @(negedge clk) begin
    if (rx_count !== prev_cnt) last_cnt_cyc <= cyc;
    prev_cnt <= rx_count;
  end

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         frame_ok;
  } txrec_t;

  txrec_t q0[$];
  txrec_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? txd_x : txd;
  endfunction

  function automatic int qsz(input bit sel);
    return sel ? q1.size() : q0.size();
  endfunction

  // Decodes one frame per falling edge, sampling mid-bit.
  task automatic tx_mon(input bit sel);
    txrec_t r;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && line(sel) === 1'b0) begin
        r.start    = cyc;
        r.data     = '0;
        r.frame_ok = 1'b1;
        repeat (4) @(negedge clk);
        if (line(sel) !== 1'b0) r.frame_ok = 1'b0;
        for (int b = 0; b < 8; b++) begin
          repeat (C) @(negedge clk);
          r.data[b] = line(sel);
        end
        repeat (C) @(negedge clk);
        if (line(sel) !== 1'b1) r.frame_ok = 1'b0;
        if (sel) q1.push_back(r);
        else     q0.push_back(r);
      end
    end
  endtask

  initial tx_mon(1'b0);
  initial tx_mon(1'b1);

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd_x = v;
    else     rxd   = v;
  endtask

  // Called at a negedge; returns at the negedge after the stop bit, line idle.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(sel, bits[i]);
      repeat (C) @(negedge clk);
    end
    drive(sel, 1'b1);
  endtask

  task automatic wait_q(input bit sel, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (qsz(sel) >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  typedef enum logic [1:0] {K_OK, K_BADSTOP, K_GLITCH} kind_e;
  typedef struct {
    bit         do_reset;
    kind_e      kind;
    logic [7:0] data;
    logic [7:0] e_leds;
    logic [7:0] e_cnt;
    bit         e_ferr;
    bit         e_echo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int     base;
    txrec_t r;

    vecs[0] = '{1'b0, K_OK,      8'hA5, 8'hA5, 8'd1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, K_GLITCH,  8'h00, 8'hA5, 8'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, K_OK,      8'h00, 8'h00, 8'd2, 1'b0, 1'b1};
    vecs[3] = '{1'b0, K_OK,      8'hFF, 8'hFF, 8'd3, 1'b0, 1'b1};
    vecs[4] = '{1'b1, K_BADSTOP, 8'h55, 8'h00, 8'd0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, K_OK,      8'h11, 8'h11, 8'd1, 1'b1, 1'b1};

    // Reset state, checked before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("rst_txd", txd, 1'b1);
    check("rst_leds", leds, 8'h00);
    check("rst_count", rx_count, 8'h00);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_txd_x", txd_x, 1'b1);
    check("rst_flags_x", {overflow_x, frame_err_x, leds_x, rx_count_x}, 18'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven single-frame vectors on u_dut.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_reset) do_reset();
      base = qsz(1'b0);
      case (vecs[i].kind)
        K_OK:      send_frame(1'b0, vecs[i].data, 1'b1);
        K_BADSTOP: send_frame(1'b0, vecs[i].data, 1'b0);
        default: begin
          rxd = 1'b0;
          repeat (3) @(negedge clk);
          rxd = 1'b1;
        end
      endcase
      repeat (2 * C) @(negedge clk);
      check($sformatf("row%0d_leds", i), leds, vecs[i].e_leds);
      check($sformatf("row%0d_count", i), rx_count, vecs[i].e_cnt);
      check($sformatf("row%0d_ferr", i), frame_err, vecs[i].e_ferr);
      check($sformatf("row%0d_ovf", i), overflow, 1'b0);
      if (vecs[i].e_echo) begin
        wait_q(1'b0, base + 1, 200);
        check($sformatf("row%0d_echo_n", i), qsz(1'b0), base + 1);
        if (qsz(1'b0) > base) begin
          r = q0[base];
          check($sformatf("row%0d_echo_data", i), r.data, vecs[i].data);
          check($sformatf("row%0d_echo_frame", i), r.frame_ok, 1'b1);
          check($sformatf("row%0d_echo_lat", i), r.start - last_cnt_cyc, 1);
        end
      end else begin
        repeat (100) @(negedge clk);
        check($sformatf("row%0d_no_echo", i), qsz(1'b0), base);
        check($sformatf("row%0d_txd_idle", i), txd, 1'b1);
      end
    end

    // XOR mask 0xFF instance.
    do_reset();
    send_frame(1'b1, 8'h3C, 1'b1);
    repeat (2 * C) @(negedge clk);
    check("xor_leds", leds_x, 8'h3C);
    check("xor_count", rx_count_x, 8'd1);
    wait_q(1'b1, 1, 200);
    check("xor_echo_n", qsz(1'b1), 1);
    if (qsz(1'b1) > 0) begin
      check("xor_echo_data", q1[0].data, 8'hC3);
      check("xor_echo_frame", q1[0].frame_ok, 1'b1);
    end

    // Overflow with tx_hold, then drain.
    do_reset();
    tx_hold = 1'b1;
    base = qsz(1'b0);
    for (int k = 1; k <= 6; k++) send_frame(1'b0, 8'(k), 1'b1);
    repeat (2 * C) @(negedge clk);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_count", rx_count, 8'd6);
    check("ovf_leds", leds, 8'h06);
    check("ovf_ferr", frame_err, 1'b0);
    check("ovf_held", qsz(1'b0), base);
    tx_hold = 1'b0;
    wait_q(1'b0, base + 4, 500);
    check("ovf_echo_n", qsz(1'b0), base + 4);
    for (int k = 0; k < 4; k++) begin
      if (qsz(1'b0) > base + k) begin
        check($sformatf("ovf_echo%0d_data", k), q0[base + k].data, 8'(k + 1));
        check($sformatf("ovf_echo%0d_frame", k), q0[base + k].frame_ok, 1'b1);
        if (k > 0)
          check($sformatf("ovf_gap%0d", k), q0[base + k].start - q0[base + k - 1].start, 10 * C + 1);
      end
    end
    repeat (150) @(negedge clk);
    check("ovf_no_extra", qsz(1'b0), base + 4);
    check("ovf_sticky", overflow, 1'b1);

    // Reset asserted mid-TX at data bit 3.
    do_reset();
    fork
      send_frame(1'b0, 8'h00, 1'b1);
    join_none
    for (int i = 0; i < 200; i++) begin
      if (txd === 1'b0) break;
      @(negedge clk);
    end
    check("mt_started", txd, 1'b0);
    repeat (4 * C + 4) @(negedge clk);
    check("mt_bit3_low", txd, 1'b0);
    check("mt_count_pre", rx_count, 8'd1);
    #1 rst = 1'b0;
    #1;
    check("mt_txd", txd, 1'b1);
    check("mt_count", rx_count, 8'd0);
    check("mt_leds", leds, 8'h00);
    check("mt_flags", {overflow, frame_err}, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (120) @(negedge clk);
    q0.delete();
    send_frame(1'b0, 8'h7E, 1'b1);
    repeat (2 * C) @(negedge clk);
    check("mt_after_leds", leds, 8'h7E);
    check("mt_after_count", rx_count, 8'd1);
    wait_q(1'b0, 1, 200);
    check("mt_after_echo_n", qsz(1'b0), 1);
    if (qsz(1'b0) > 0) begin
      check("mt_after_data", q0[0].data, 8'h7E);
      check("mt_after_frame", q0[0].frame_ok, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
